// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search design.
package arc4_pkg;

  localparam int          KEY_WIDTH = 24;
  localparam logic [23:0] MAX_KEY   = 24'hFFFFFF;
  localparam logic [7:0]  ASCII_LO  = 8'h20;
  localparam logic [7:0]  ASCII_HI  = 8'h7E;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    PRGA,
    NEXT,
    DONE
  } core_state_t;

  // Active-low 7-segment pattern for one hex nibble (bit 6 = segment g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // A decrypted byte is acceptable only if it is printable ASCII.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_LO) && (b <= ASCII_HI);
  endfunction

endpackage

// File: rtl/arc4_core.sv
// One ARC4 key-search core: walks keys start_key, start_key+stride, ...
// S lives in registers so every KSA/PRGA step is a single cycle.
module arc4_core #(
  parameter int                   KEY_WIDTH = arc4_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] MAX_KEY   = arc4_pkg::MAX_KEY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_WIDTH-1:0] start_key,
  input  logic [KEY_WIDTH-1:0] stride,
  input  logic                 stop,
  output logic [7:0]           ct_addr,
  input  logic [7:0]           ct_data,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH-1:0] cur_key,
  output logic [7:0]           pt_buf [256]
);
  import arc4_pkg::*;

  core_state_t          state, state_next;
  logic [7:0]           s [256];
  logic [7:0]           idx, jdx, pos, len;
  logic [1:0]           kmod;
  logic [KEY_WIDTH-1:0] key_reg;
  logic                 found_set, exh_set;

  logic [7:0]           key_byte;
  logic [7:0]           ksa_si, ksa_j, ksa_sj;
  logic [7:0]           pr_i, pr_si, pr_j, pr_sj, pr_t, pr_ks, pt_byte;
  logic                 pt_ok;
  logic [KEY_WIDTH:0]   key_sum;
  logic                 key_over;

  assign cur_key = key_reg;

  // Key bytes are taken big-endian, cycling with i mod 3.
  always_comb begin
    case (kmod)
      2'd0:    key_byte = key_reg[KEY_WIDTH-1 -: 8];
      2'd1:    key_byte = key_reg[KEY_WIDTH-9 -: 8];
      default: key_byte = key_reg[KEY_WIDTH-17 -: 8];
    endcase
  end

  assign ksa_si = s[idx];
  assign ksa_j  = jdx + ksa_si + key_byte;
  assign ksa_sj = s[ksa_j];

  assign pr_i   = idx + 8'd1;
  assign pr_si  = s[pr_i];
  assign pr_j   = jdx + pr_si;
  assign pr_sj  = s[pr_j];
  assign pr_t   = pr_si + pr_sj;
  // The keystream index is read from the post-swap S, so forward the swapped values.
  assign pr_ks  = (pr_t == pr_i) ? pr_sj : (pr_t == pr_j) ? pr_si : s[pr_t];
  assign pt_byte = pr_ks ^ ct_data;
  assign pt_ok   = is_printable(pt_byte);

  assign key_sum  = {1'b0, key_reg} + {1'b0, stride};
  assign key_over = key_sum > {1'b0, MAX_KEY};

  // ct is read one cycle ahead: ct[0] while initialising, ct[1] during KSA, ct[k+1] in PRGA.
  always_comb begin
    ct_addr = 8'd0;
    if (state == KSA) begin
      ct_addr = 8'd1;
    end else if (state == PRGA) begin
      ct_addr = pos + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; stop from the top overrides everything.
  always_comb begin
    state_next = state;
    found_set  = 1'b0;
    exh_set    = 1'b0;
    case (state)
      IDLE: state_next = INIT;
      INIT: if (idx == 8'hFF) state_next = KSA;
      KSA:  if (idx == 8'hFF) state_next = PRGA;
      PRGA: begin
        if (len == 8'd0) begin
          state_next = DONE;
          found_set  = 1'b1;
        end else if (!pt_ok) begin
          state_next = NEXT;
        end else if (pos == len) begin
          state_next = DONE;
          found_set  = 1'b1;
        end
      end
      NEXT: begin
        if (key_over) begin
          state_next = DONE;
          exh_set    = 1'b1;
        end else begin
          state_next = INIT;
        end
      end
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (stop) begin
      state_next = DONE;
      found_set  = 1'b0;
      exh_set    = 1'b0;
    end
  end

  // Loop counters, message length, current key and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= 8'd0;
      jdx       <= 8'd0;
      kmod      <= 2'd0;
      pos       <= 8'd1;
      len       <= 8'd0;
      key_reg   <= start_key;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      found     <= found | found_set;
      exhausted <= exhausted | exh_set;
      case (state)
        INIT: begin
          idx  <= idx + 8'd1;
          jdx  <= 8'd0;
          kmod <= 2'd0;
          pos  <= 8'd1;
          len  <= ct_data;
        end
        KSA: begin
          idx  <= idx + 8'd1;
          jdx  <= (idx == 8'hFF) ? 8'd0 : ksa_j;
          kmod <= (kmod == 2'd2) ? 2'd0 : kmod + 2'd1;
        end
        PRGA: begin
          if (len != 8'd0) begin
            idx <= pr_i;
            jdx <= pr_j;
            pos <= pos + 8'd1;
          end
        end
        NEXT: begin
          idx <= 8'd0;
          if (!key_over) key_reg <= key_sum[KEY_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // S permutation and plaintext buffer; contents are rebuilt for every key, so no reset.
  always_ff @(posedge clk) begin
    case (state)
      INIT: begin
        s[idx] <= idx;
        if (idx == 8'hFF) pt_buf[0] <= ct_data;
      end
      KSA: begin
        s[idx]   <= ksa_sj;
        s[ksa_j] <= ksa_si;
      end
      PRGA: begin
        if (len != 8'd0) begin
          s[pr_i]     <= pr_sj;
          s[pr_j]     <= pr_si;
          pt_buf[pos] <= pt_byte;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/crack_top.sv
// ARC4 key cracker: NUM_CORES interleaved search cores, winner capture and display.
module crack_top #(
  parameter int                   NUM_CORES = 2,
  parameter int                   KEY_WIDTH = arc4_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] MAX_KEY   = arc4_pkg::MAX_KEY
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);
  import arc4_pkg::*;

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic clk;
  logic rst_n;
  logic unused_inputs;

  assign clk           = CLOCK_50;
  assign rst_n         = KEY[3];
  assign unused_inputs = ^{KEY[2:0], SW};

  // Ciphertext store: ct[0] = length, ct[1..L] = ciphertext. Never reset.
  logic [7:0] ct [256];
  logic       ct_load_en;
  logic [7:0] ct_load_addr, ct_load_data;

  // Loader hook left idle; the store is normally preloaded from outside.
  assign ct_load_en   = 1'b0;
  assign ct_load_addr = 8'd0;
  assign ct_load_data = 8'd0;

  // Optional ciphertext write path.
  always_ff @(posedge clk) begin
    if (ct_load_en) ct[ct_load_addr] <= ct_load_data;
  end

  logic                                 key_valid;
  logic [KEY_WIDTH-1:0]                 key;
  logic [7:0]                           pt [256];
  logic                                 done;
  logic                                 stop;
  logic                                 any_found;
  logic [CW-1:0]                        win_idx;
  logic [NUM_CORES-1:0]                 found_vec, exh_vec;
  logic [NUM_CORES-1:0][KEY_WIDTH-1:0]  core_key;
  logic [7:0]                           core_pt [NUM_CORES][256];

  assign stop = any_found | done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [7:0] ct_addr;
      logic [7:0] ct_rd;

      // Private registered read port into the ciphertext store.
      always_ff @(posedge clk) begin
        ct_rd <= ct[ct_addr];
      end

      arc4_core #(
        .KEY_WIDTH (KEY_WIDTH),
        .MAX_KEY   (MAX_KEY)
      ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_key (KEY_WIDTH'(gi)),
        .stride    (KEY_WIDTH'(NUM_CORES)),
        .stop      (stop),
        .ct_addr   (ct_addr),
        .ct_data   (ct_rd),
        .found     (found_vec[gi]),
        .exhausted (exh_vec[gi]),
        .cur_key   (core_key[gi]),
        .pt_buf    (core_pt[gi])
      );
    end
  endgenerate

  // Lowest-numbered finder wins a simultaneous find.
  always_comb begin
    any_found = 1'b0;
    win_idx   = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (found_vec[c]) begin
        any_found = 1'b1;
        win_idx   = CW'(c);
      end
    end
  end

  // Capture the first winner (key and plaintext) or note exhaustion of every core.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key       <= '0;
      done      <= 1'b0;
      for (int a = 0; a < 256; a++) pt[a] <= 8'd0;
    end else if (!done) begin
      if (any_found) begin
        key_valid <= 1'b1;
        key       <= core_key[win_idx];
        done      <= 1'b1;
        for (int a = 0; a < 256; a++) pt[a] <= core_pt[win_idx][a];
      end else if (&exh_vec) begin
        done <= 1'b1;
      end
    end
  end

  // pt is observed through the hierarchy until a readout port is attached.
  logic [7:0] unused_pt;
  always_comb begin
    unused_pt = 8'd0;
    for (int a = 0; a < 256; a++) unused_pt = unused_pt ^ pt[a];
  end

  logic [23:0] key_disp;
  assign key_disp = 24'(key);

  // Status LEDs and 7-segment display: blank, key in hex, or dashes.
  always_comb begin
    LEDR = {8'd0, key_valid, done};
    HEX0 = SEG_BLANK;
    HEX1 = SEG_BLANK;
    HEX2 = SEG_BLANK;
    HEX3 = SEG_BLANK;
    HEX4 = SEG_BLANK;
    HEX5 = SEG_BLANK;
    if (done) begin
      if (key_valid) begin
        HEX5 = hex_to_seg(key_disp[23:20]);
        HEX4 = hex_to_seg(key_disp[19:16]);
        HEX3 = hex_to_seg(key_disp[15:12]);
        HEX2 = hex_to_seg(key_disp[11:8]);
        HEX1 = hex_to_seg(key_disp[7:4]);
        HEX0 = hex_to_seg(key_disp[3:0]);
      end else begin
        HEX0 = SEG_DASH;
        HEX1 = SEG_DASH;
        HEX2 = SEG_DASH;
        HEX3 = SEG_DASH;
        HEX4 = SEG_DASH;
        HEX5 = SEG_DASH;
      end
    end
  end

endmodule

// File: tb/tb_crack_top.sv
// Directed bench for crack_top: known-key messages, empty message, mid-search
// reset and an exhaustion run on a second instance with a tiny key space.
module tb_crack_top;

  logic       clk = 1'b0;
  logic [3:0] key_in   = 4'b0111;
  logic [3:0] key_in_x = 4'b0111;
  logic [9:0] sw       = 10'd0;
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [6:0] x0, x1, x2, x3, x4, x5;
  logic [9:0] ledr, ledr_x;

  always #5 clk = ~clk;

  crack_top dut (
    .CLOCK_50 (clk),
    .KEY      (key_in),
    .SW       (sw),
    .HEX0     (h0),
    .HEX1     (h1),
    .HEX2     (h2),
    .HEX3     (h3),
    .HEX4     (h4),
    .HEX5     (h5),
    .LEDR     (ledr)
  );

  crack_top #(.MAX_KEY(24'h00000F)) dut_x (
    .CLOCK_50 (clk),
    .KEY      (key_in_x),
    .SW       (sw),
    .HEX0     (x0),
    .HEX1     (x1),
    .HEX2     (x2),
    .HEX3     (x3),
    .HEX4     (x4),
    .HEX5     (x5),
    .LEDR     (ledr_x)
  );

  int         compares = 0;
  int         fails    = 0;
  logic [7:0] ks [257];
  logic [7:0] ct1_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ARC4 keystream bytes 1..n for a 3-byte big-endian key, into ks[].
  task automatic gen_ks(input logic [23:0] k, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + s[a] + kb[a % 3];
      t = s[a];
      s[a] = s[j];
      s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int n1 = 1; n1 <= n; n1++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      ks[n1] = s[8'(s[i] + s[j])];
    end
  endtask

  task automatic load_msg(input string msg, input logic [23:0] k);
    int n;
    n = msg.len();
    gen_ks(k, n);
    dut.ct[0] = 8'(n);
    for (int p = 1; p <= n; p++) dut.ct[p] = msg[p-1] ^ ks[p];
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    key_in[3] = 1'b0;
    repeat (n) @(negedge clk);
    key_in[3] = 1'b1;
  endtask

  // Wait for LEDR[0] of the chosen instance; an expired budget is a failed comparison.
  task automatic wait_done(input int which, input int budget, input string tag);
    int c;
    logic d;
    c = 0;
    d = (which == 0) ? ledr[0] : ledr_x[0];
    while (!d && c < budget) begin
      @(negedge clk);
      c++;
      d = (which == 0) ? ledr[0] : ledr_x[0];
    end
    check({tag, "_done"}, 64'(d), 64'd1);
    $display("%s: search finished after %0d cycles", tag, c);
  endtask

  initial begin
    // Exhaustion instance: key p-1 decrypts byte p to 0x00, so no key 0..15 survives.
    dut_x.ct[0] = 8'd16;
    for (int p = 1; p <= 16; p++) begin
      gen_ks(24'(p - 1), p);
      dut_x.ct[p] = ks[p];
    end
    load_msg("Hi", 24'h000000);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_kv",   64'(dut.key_valid), 64'd0);
    check("rst_key",  64'(dut.key), 64'd0);
    check("rst_ledr", 64'(ledr), 64'd0);
    check("rst_hex",  64'({h5, h4, h3, h2, h1, h0}), 64'({6{7'h7F}}));
    check("rst_pt1",  64'(dut.pt[1]), 64'd0);
    check("rst_ledr_x", 64'(ledr_x), 64'd0);
    $display("reset: state checked");

    key_in[3]   = 1'b1;
    key_in_x[3] = 1'b1;

    // Searching: display blank, LEDs off.
    repeat (10) @(negedge clk);
    check("srch_hex",  64'({h5, h4, h3, h2, h1, h0}), 64'({6{7'h7F}}));
    check("srch_ledr", 64'(ledr), 64'd0);

    // "Hi" under key 000000.
    wait_done(0, 2000, "hi");
    check("hi_kv",   64'(dut.key_valid), 64'd1);
    check("hi_key",  64'(dut.key), 64'h000000);
    check("hi_pt0",  64'(dut.pt[0]), 64'h02);
    check("hi_pt1",  64'(dut.pt[1]), 64'h48);
    check("hi_pt2",  64'(dut.pt[2]), 64'h69);
    check("hi_hex",  64'({h5, h4, h3, h2, h1, h0}), 64'({6{7'h40}}));
    check("hi_ledr", 64'(ledr), 64'b11);

    // Empty message passes on the very first key.
    dut.ct[0] = 8'd0;
    reset_pulse(2);
    wait_done(0, 520, "empty");
    check("empty_kv",  64'(dut.key_valid), 64'd1);
    check("empty_key", 64'(dut.key), 64'h000000);
    check("empty_pt0", 64'(dut.pt[0]), 64'd0);

    // Ten printable bytes under key 000018.
    load_msg("ARC4 crack", 24'h000018);
    ct1_exp = dut.ct[1];
    reset_pulse(2);
    wait_done(0, 100000, "k18");
    check("k18_kv",   64'(dut.key_valid), 64'd1);
    check("k18_key",  64'(dut.key), 64'h000018);
    check("k18_led",  64'(ledr[1:0]), 64'b11);
    check("k18_pt1",  64'(dut.pt[1]), 64'h41);
    check("k18_pt10", 64'(dut.pt[10]), 64'h6B);
    check("k18_hex",  64'({h5, h4, h3, h2, h1, h0}),
          64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h00}));

    // Reset during KSA of the first keys, then let it run to completion.
    reset_pulse(2);
    repeat (300) @(negedge clk);
    key_in[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_kv",   64'(dut.key_valid), 64'd0);
    check("mid_key",  64'(dut.key), 64'd0);
    check("mid_ledr", 64'(ledr), 64'd0);
    check("mid_hex",  64'({h5, h4, h3, h2, h1, h0}), 64'({6{7'h7F}}));
    check("mid_pt1",  64'(dut.pt[1]), 64'd0);
    check("mid_ct0",  64'(dut.ct[0]), 64'd10);
    check("mid_ct1",  64'(dut.ct[1]), 64'(ct1_exp));
    key_in[3] = 1'b1;
    wait_done(0, 100000, "mid");
    check("mid_key_end", 64'(dut.key), 64'h000018);
    check("mid_kv_end",  64'(dut.key_valid), 64'd1);

    // Exhausted search on the small key space.
    wait_done(1, 20000, "exh");
    check("exh_led", 64'(ledr_x[1:0]), 64'b01);
    check("exh_kv",  64'(dut_x.key_valid), 64'd0);
    check("exh_hex", 64'({x5, x4, x3, x2, x1, x0}), 64'({6{7'h3F}}));
    check("exh_ledr_hi", 64'(ledr_x[9:2]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/crack_top.md
CRACK_TOP -- requirements
Module: crack_top

Interface
REQ-001 Parameter NUM_CORES, default 2, number of parallel ARC4 crack cores.
REQ-002 Parameter KEY_WIDTH, default 24, key width in bits (3 key bytes).
REQ-003 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-004 KEY  in  4  KEY[3] = reset, synchronous, active-low; KEY[2:0] unused.
REQ-005 SW  in  10  unused.
REQ-006 HEX0..HEX5  out  7 each  active-low 7-segment digits; HEX5 most significant.
REQ-007 LEDR  out  10  LEDR[0] done, LEDR[1] key found, LEDR[9:2] = 0.
REQ-008 Internal signals key_valid (1 bit) and key (KEY_WIDTH bits) SHALL exist at top level under exactly these names.
REQ-009 Ciphertext store SHALL be a 256x8 array named ct, not cleared by reset, preloadable by simulation; ct[0] = message length L, ct[1..L] = ciphertext.

Function
REQ-010 Key bytes SHALL be big-endian: key byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0].
REQ-011 Core c SHALL test keys c, c+NUM_CORES, c+2*NUM_CORES, ...; search SHALL start at key 0 on the cycle after reset release.
REQ-012 Per-core states: IDLE, INIT, KSA, PRGA, NEXT, DONE.
REQ-013 INIT: S[i] = i, one i per cycle, i = 0..255 (256 cycles).
REQ-014 KSA: j = 0; per cycle for i = 0..255: j = j + S[i] + keybyte[i mod 3] (mod 256), swap S[i], S[j] (256 cycles).
REQ-015 PRGA: i = j = 0; per cycle for k = 1..L: i = i+1, j = j+S[i], swap S[i], S[j], pt_k = S[(S[i]+S[j]) mod 256] XOR ct[k]; all arithmetic 8-bit wrap.
REQ-016 Each core SHALL write pt_k into its private 256x8 plaintext buffer at index k, with buffer[0] = L.
REQ-017 A byte outside 0x20..0x7E SHALL abort the key immediately (early exit to NEXT).
REQ-018 All L bytes in range SHALL declare the key found; L = 0 SHALL pass trivially.
REQ-019 NEXT: key += NUM_CORES; if result > 0xFFFFFF the core SHALL enter DONE as exhausted.
REQ-020 On first found, top SHALL set key_valid = 1, latch key, copy the winning buffer into 256x8 array pt in the same cycle, and force all cores to DONE.
REQ-021 Simultaneous finds SHALL be resolved in favour of the lowest core index.
REQ-022 Search is done when a key is found or all cores are exhausted; key_valid = 0 on exhaustion.
REQ-023 HEX: blank (7'h7F) while searching; key nibbles in hex on HEX5..HEX0 when found; dash (7'h3F) on all digits when exhausted.

Reset
REQ-024 KEY[3] = 0 at a clock edge SHALL force all cores to IDLE, key_valid = 0, key = 0, pt cleared, HEX all 7'h7F, LEDR = 0.
REQ-025 Reset mid-search SHALL abandon progress; search SHALL restart at key 0 after release; ct SHALL be preserved.

Structure
REQ-026 Package arc4_pkg SHALL hold the state enum, KEY_WIDTH, MAX_KEY (24'hFFFFFF), and ASCII bounds 0x20/0x7E.
REQ-027 Sub-module arc4_core SHALL be instantiated NUM_CORES times: inputs start key, stride, ct read port, stop; outputs found, exhausted, current key, plaintext buffer.
REQ-028 S SHALL be a per-core register array so every KSA/PRGA step completes in one cycle; a key costs at most 513 + L cycles.

Verification
REQ-029 ct encrypting "Hi" with key 0x000000 (L = 2), reset pulse -> key_valid = 1, key = 0x000000, pt[1..2] = 0x48 0x69, HEX = "000000".
REQ-030 ct encrypting 10 printable bytes with key 0x000018 -> within 100000 cycles key_valid = 1, key = 0x000018 (odd/even core tie-break exercised), LEDR[1:0] = 2'b11.
REQ-031 ct[0] = 0 -> key_valid = 1, key = 0x000000 within 520 cycles.
REQ-032 Reset asserted mid-KSA, released after 2 cycles -> outputs cleared, key_valid = 0, search restarts at key 0, same final key as without the interruption.
REQ-033 MAX_KEY overridden to 0x00000F with ct not decryptable by any key -> LEDR[1:0] = 2'b01, key_valid = 0, all HEX = 7'h3F.
